bht_ctrl: RTL

Branch-history-table controller: owns a table of 2^IDX_W N-bit saturating counters and schedules table access between a fetch-side prediction port and a commit-side update port. It indexes the table gshare-style (PC bits XOR global history), runs a table-clearing sequence after reset or flush, and counts mispredictions. It sits between the fetch stage, which requests predictions, and the branch-resolve stage, which reports outcomes.

---
 rtl/bht_ctrl_pkg.sv | 26 ++
 rtl/bht_ctrl_if.sv | 33 +++
 rtl/bht_ctr_next.sv | 21 ++
 rtl/bht_ctrl.sv | 127 ++++++++++++
 4 files changed

// File: rtl/bht_ctrl_pkg.sv
// Shared definitions for the branch-history-table controller: default
// geometry, controller state encoding, gshare index hash and taken test.
package bp_pkg;

  localparam int BP_N      = 2;
  localparam int BP_IDX_W  = 4;
  localparam int BP_HIST_W = 4;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_e;

  // gshare index: word-aligned PC bits XOR zero-extended history, masked to idx_w bits
  function automatic logic [31:0] bp_hash(input logic [31:0] pc,
                                          input logic [31:0] ghr,
                                          input int          idx_w);
    return ((pc >> 2) ^ ghr) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // A counter predicts taken when it sits in the upper half of its range
  function automatic logic bp_taken(input logic [31:0] ctr, input int n);
    return (ctr >= (32'd1 << (n - 1)));
  endfunction

endpackage

// File: rtl/bht_ctrl_if.sv
// Fetch/resolve-side bundle of the branch-history-table controller.
// master = fetch + branch-resolve stages, slave = controller.
interface bht_ctrl_if #(parameter int IDX_W = bp_pkg::BP_IDX_W);

  logic             pred_valid;
  logic [31:0]      pred_pc;
  logic             pred_ready;
  logic             pred_resp_valid;
  logic             pred_taken;
  logic [IDX_W-1:0] pred_index;

  logic             upd_valid;
  logic [IDX_W-1:0] upd_index;
  logic             upd_taken;
  logic             upd_pred;
  logic             upd_ready;

  logic             init_done;
  logic [15:0]      mispred_cnt;

  modport master (
    output pred_valid, pred_pc, upd_valid, upd_index, upd_taken, upd_pred,
    input  pred_ready, pred_resp_valid, pred_taken, pred_index, upd_ready,
           init_done, mispred_cnt
  );

  modport slave (
    input  pred_valid, pred_pc, upd_valid, upd_index, upd_taken, upd_pred,
    output pred_ready, pred_resp_valid, pred_taken, pred_index, upd_ready,
           init_done, mispred_cnt
  );

endinterface

// File: rtl/bht_ctr_next.sv
// Next value of an N-bit saturating counter: taken counts up, not-taken
// counts down, both clamped at the ends of the range.
module bht_ctr_next #(
  parameter int N = 2
) (
  input  logic [N-1:0] i_ctr,
  input  logic         i_taken,
  output logic [N-1:0] o_next
);

  // Saturating increment/decrement
  always_comb begin
    o_next = i_ctr;
    if (i_taken) begin
      if (i_ctr != '1) o_next = i_ctr + 1'b1;
    end else begin
      if (i_ctr != '0) o_next = i_ctr - 1'b1;
    end
  end

endmodule

// File: rtl/bht_ctrl.sv
// Branch-history-table controller: gshare-indexed table of saturating
// counters, table clear after reset/flush, prediction and update ports,
// misprediction counter.
module bht_ctrl
  import bp_pkg::*;
#(
  parameter int N      = BP_N,
  parameter int IDX_W  = BP_IDX_W,
  parameter int HIST_W = BP_HIST_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  bht_ctrl_if.slave    bus
);

  localparam int DEPTH = 1 << IDX_W;

  bp_state_e          r_state;
  logic [IDX_W-1:0]   r_init_ptr;
  logic [HIST_W-1:0]  r_ghr;
  logic [15:0]        r_mispred;
  logic [N-1:0]       r_tbl [DEPTH];

  logic               r_vld_p0;
  logic [N-1:0]       r_ctr_p0;
  logic [IDX_W-1:0]   r_idx_p0;
  logic               r_vld_p1;
  logic               r_taken_p1;
  logic [IDX_W-1:0]   r_idx_p1;

  logic               w_run;
  logic               w_pred_acc;
  logic               w_upd_acc;
  logic [IDX_W-1:0]   w_pred_idx;
  logic [N-1:0]       w_upd_ctr;
  logic [N-1:0]       w_upd_next;

  assign w_run      = (r_state == RUN);
  assign w_pred_acc = w_run & bus.pred_valid & ~flush & ~reset;
  assign w_upd_acc  = w_run & bus.upd_valid  & ~flush & ~reset;
  assign w_pred_idx = IDX_W'(bp_hash(bus.pred_pc, 32'(r_ghr), IDX_W));
  assign w_upd_ctr  = r_tbl[bus.upd_index];

  bht_ctr_next #(.N(N)) u_ctr_next (
    .i_ctr   (w_upd_ctr),
    .i_taken (bus.upd_taken),
    .o_next  (w_upd_next)
  );

  // Control FSM: table-clear sequence, history register, mispredict count
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= INIT;
      r_init_ptr <= '0;
      r_ghr      <= '0;
      r_mispred  <= '0;
    end else if (flush) begin
      r_state    <= INIT;
      r_init_ptr <= '0;
      r_ghr      <= '0;
    end else begin
      case (r_state)
        INIT: begin
          r_init_ptr <= r_init_ptr + 1'b1;
          if (&r_init_ptr) r_state <= RUN;
        end
        RUN: begin
          if (w_upd_acc) begin
            r_ghr <= {r_ghr[HIST_W-2:0], bus.upd_taken};
            if ((bus.upd_pred != bus.upd_taken) && (r_mispred != 16'hFFFF))
              r_mispred <= r_mispred + 16'd1;
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  // Counter table: zero-fill during INIT, saturating update in RUN
  always_ff @(posedge clk) begin
    if (r_state == INIT)
      r_tbl[r_init_ptr] <= '0;
    else if (w_upd_acc)
      r_tbl[bus.upd_index] <= w_upd_next;
  end

  // Stage p0: capture pre-edge counter value and index of an accepted request
  always_ff @(posedge clk) begin
    if (reset || flush) r_vld_p0 <= 1'b0;
    else                r_vld_p0 <= w_pred_acc;
  end

  // Stage p0 data path (no reset needed; qualified by r_vld_p0)
  always_ff @(posedge clk) begin
    if (w_pred_acc) begin
      r_ctr_p0 <= r_tbl[w_pred_idx];
      r_idx_p0 <= w_pred_idx;
    end
  end

  // Stage p1: registered response; flush squashes a request in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1   <= 1'b0;
      r_taken_p1 <= 1'b0;
      r_idx_p1   <= '0;
    end else if (flush) begin
      r_vld_p1   <= 1'b0;
    end else begin
      r_vld_p1 <= r_vld_p0;
      if (r_vld_p0) begin
        r_taken_p1 <= bp_taken(32'(r_ctr_p0), N);
        r_idx_p1   <= r_idx_p0;
      end
    end
  end

  assign bus.pred_ready      = w_run;
  assign bus.upd_ready       = w_run;
  assign bus.init_done       = w_run;
  assign bus.pred_resp_valid = r_vld_p1;
  assign bus.pred_taken      = r_taken_p1;
  assign bus.pred_index      = r_idx_p1;
  assign bus.mispred_cnt     = r_mispred;

endmodule
